sliding_window_gen: RTL and testbench
=====================================

Name: sliding_window_gen

Overview:
Parametrised WIN x WIN pixel neighbourhood generator for the streaming video path. It sits between the pixel input stage and the convolution/filter kernels. It uses WIN-1 line buffers with synchronous read and a WIN x WIN register array. Unlike the fixed 5x5 window, it tracks frame and line position, supports input gaps, and flags a window as valid only when every element holds real pixels of the current frame.

Parameters:
DATA_W, 8, bits per pixel
WIN, 5, window edge length; odd, 3..7
LINE_W, 1280, maximum active pixels per line (line buffer depth)
ADDR_W, 11, line buffer address width; must satisfy 2^ADDR_W >= LINE_W

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_data  in  DATA_W  incoming pixel
in_valid  in  1  pixel accepted this cycle; no backpressure
in_sof  in  1  qualifies in_data as first pixel of frame (valid only with in_valid)
in_eol  in  1  qualifies in_data as last pixel of line (valid only with in_valid)
out_window  out  DATA_W*WIN*WIN  element (r,c) at bits [(r*WIN+c+1)*DATA_W-1 : (r*WIN+c)*DATA_W]; r=0 oldest/top row, c=0 oldest/left column
out_valid  out  1  out_window holds a fully populated window
out_eol  out  1  out_window's bottom-right pixel was an in_eol pixel
err_overrun  out  1  sticky: line exceeded LINE_W without in_eol

Behaviour:
- Reset: out_window=0, out_valid=0, out_eol=0, err_overrun=0. Column counter col=0, row counter row=0, state WAIT_SOF.
- States: WAIT_SOF drops all input until in_valid&in_sof, then goes to ACTIVE. ACTIVE accepts pixels. rst from any state returns to WAIT_SOF. A reset mid-frame discards the rest of that frame.
- Accept (ACTIVE & in_valid): pixel is written to line buffer 0 at address col. Buffer k output is written to buffer k+1 at the same address (read-before-write). The WIN-pixel column (new pixel plus WIN-1 buffer reads) shifts into column WIN-1 of the register array; the existing columns shift left.
- in_sof while ACTIVE restarts the frame: col=0, row=0, pixel treated as first. Buffers are not cleared; stale data is masked by out_valid gating.
- Position counters: col increments per accept. On in_eol: col=0 and row increments, saturating at WIN-1. If col reaches LINE_W-1 and the pixel is not in_eol, treat it as an implicit eol and set err_overrun; only rst clears err_overrun.
- Window column register c is loaded only with pixels of the current line. On in_eol, the next accept begins a new line, and the window is valid only once WIN pixels of that line are in.
- out_valid=1 iff the accepted pixel had row==WIN-1 and col>=WIN-1 at acceptance. Pixels accepted with row<WIN-1 (first WIN-1 lines) produce out_valid=0.
- Latency: exactly 2 clk from an accepting in_valid edge to the matching out_valid/out_window (1 for RAM read, 1 for output register), independent of input gaps. With no accept, out_valid=0 the cycle 2 later. out_window holds its last value.
- out_eol is pipelined alongside out_valid with the same latency and is asserted only together with out_valid.
- Simultaneous in_sof and in_eol on one pixel: the line is 1 pixel long. The sof reset is applied first, then eol advances the row.

Optional Feature:
WINDOW_COORD_EN
- Defined: adds outputs out_x (ADDR_W) and out_y (16). They give the column and the line-within-frame of the window centre pixel, pipelined with out_valid. out_y counts full lines since in_sof and does not saturate.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Bench uses WIN=3, LINE_W=8. rst for 2 clk, then a 4x8 frame with pixel=row*16+col and in_valid continuous -> first out_valid 2 clk after pixel (2,2). out_window row0..2 = {0x00,0x01,0x02},{0x10,0x11,0x12},{0x20,0x21,0x22}. 6 valid windows per line for lines 2,3 -> 12 total.
- Same frame with in_valid toggling 1/0 -> identical 12 windows in the same order; each out_valid exactly 2 clk after its accepting edge.
- Pixels before any in_sof after reset -> out_valid stays 0. Then a frame with in_sof -> matches scenario 1.
- Line of 10 pixels without in_eol (LINE_W=8) -> err_overrun=1 after the 8th pixel and stays 1 until rst. The next line's column restarts at 0.
- Second in_sof mid-frame at row 3 col 4 -> no out_valid for the next 2 lines of the new frame. The first window contains only new-frame pixels.
- rst asserted during row 2 -> outputs 0 next clk, input ignored until in_sof.

Source files
------------

// File: rtl/sliding_window_gen_if.sv
// ---------------------------------------------------------------------------
// sliding_window_gen_if
// Pixel-stream and window-output bundle for sliding_window_gen.
//   master : drives in_data/in_valid/in_sof/in_eol, observes window outputs
//   slave  : the window generator itself
// Signals:
//   in_data     pixel, DATA_W bits
//   in_valid    pixel present this cycle (no backpressure)
//   in_sof      first pixel of frame (qualified by in_valid)
//   in_eol      last pixel of line   (qualified by in_valid)
//   out_window  WIN x WIN window, element (r,c) at slice r*WIN+c
//   out_valid   window fully populated with current-frame pixels
//   out_eol     bottom-right pixel of the window carried in_eol
//   err_overrun sticky line-overrun flag
// Optional (macro WINDOW_COORD_EN): out_x / out_y window-centre coordinates.
// ---------------------------------------------------------------------------
interface sliding_window_gen_if #(
    parameter int DATA_W = 8,
    parameter int WIN    = 5
`ifdef WINDOW_COORD_EN
    , parameter int ADDR_W = 11
`endif
);
    logic [DATA_W-1:0]         in_data;
    logic                      in_valid;
    logic                      in_sof;
    logic                      in_eol;
    logic [DATA_W*WIN*WIN-1:0] out_window;
    logic                      out_valid;
    logic                      out_eol;
    logic                      err_overrun;
`ifdef WINDOW_COORD_EN
    logic [ADDR_W-1:0]         out_x;
    logic [15:0]               out_y;
`endif

    modport master (
        output in_data, in_valid, in_sof, in_eol,
`ifdef WINDOW_COORD_EN
        input  out_x, out_y,
`endif
        input  out_window, out_valid, out_eol, err_overrun
    );

    modport slave (
        input  in_data, in_valid, in_sof, in_eol,
`ifdef WINDOW_COORD_EN
        output out_x, out_y,
`endif
        output out_window, out_valid, out_eol, err_overrun
    );
endinterface

// File: rtl/sliding_window_gen.sv
// ---------------------------------------------------------------------------
// sliding_window_gen
// WIN x WIN pixel neighbourhood generator for a streaming video path.
// WIN-1 line buffers (registered-read RAM) feed a WIN x WIN register array.
// Tracks frame/line position, tolerates input gaps and raises out_valid only
// when every window element is a real pixel of the current frame.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  sliding_window_gen_if.slave (pixel input, window output, status)
// Pipeline: accept edge -> input register -> RAM read -> output register,
// so a window appears exactly 2 clk after its accepting edge.
// Optional feature, macro WINDOW_COORD_EN: adds bus.out_x / bus.out_y, the
// column and line-within-frame of the window centre pixel.
// ---------------------------------------------------------------------------
module sliding_window_gen #(
    parameter int DATA_W = 8,
    parameter int WIN    = 5,
    parameter int LINE_W = 1280,
    parameter int ADDR_W = 11
) (
    input  logic                clk,
    input  logic                rst,
    sliding_window_gen_if.slave bus
);
    localparam int                ROW_W    = $clog2(WIN);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_W - 1);
    localparam logic [ADDR_W-1:0] EDGE_COL = ADDR_W'(WIN - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(WIN - 1);

    typedef enum logic {WAIT_SOF, ACTIVE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] col_reg, col_next, col_eff;
    logic [ROW_W-1:0]  row_reg, row_next, row_eff;
    logic              err_reg, err_next;
    logic              accept, line_end, overrun, win_ok;

    // Input register stage (s0) and RAM-read stage (s1)
    logic              s0_acc, s0_win_ok, s0_eol;
    logic [DATA_W-1:0] s0_pix;
    logic [ADDR_W-1:0] s0_addr;
    logic              s1_acc, s1_win_ok, s1_eol;
    logic [DATA_W-1:0] s1_pix;
    logic [ADDR_W-1:0] s1_addr;

    logic [DATA_W-1:0]                rd_data [WIN-1];
    logic [DATA_W-1:0]                col_in  [WIN];
    logic [WIN-1:0][WIN*DATA_W-1:0]   win_reg;
    logic                             out_valid_reg, out_eol_reg;

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        err_next   = err_reg;
        accept     = 1'b0;
        line_end   = 1'b0;
        overrun    = 1'b0;
        win_ok     = 1'b0;
        col_eff    = col_reg;
        row_eff    = row_reg;
        // A start-of-frame pixel always restarts position before anything else
        if (bus.in_valid && bus.in_sof) begin
            col_eff = '0;
            row_eff = '0;
        end
        case (state_reg)
            WAIT_SOF: begin
                if (bus.in_valid && bus.in_sof) begin
                    state_next = ACTIVE;
                    accept     = 1'b1;
                end
            end
            ACTIVE:   accept = bus.in_valid;
            default:  state_next = WAIT_SOF;
        endcase
        if (accept) begin
            overrun  = (col_eff == LAST_COL) && !bus.in_eol;
            line_end = bus.in_eol || overrun;
            win_ok   = (row_eff == LAST_ROW) && (col_eff >= EDGE_COL);
            if (line_end) begin
                col_next = '0;
                row_next = (row_eff == LAST_ROW) ? row_eff : row_eff + 1'b1;
            end else begin
                col_next = col_eff + 1'b1;
                row_next = row_eff;
            end
            if (overrun) begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= WAIT_SOF;
            col_reg   <= '0;
            row_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            err_reg   <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_acc    <= 1'b0;
            s0_win_ok <= 1'b0;
            s0_eol    <= 1'b0;
            s0_pix    <= '0;
            s0_addr   <= '0;
            s1_acc    <= 1'b0;
            s1_win_ok <= 1'b0;
            s1_eol    <= 1'b0;
            s1_pix    <= '0;
            s1_addr   <= '0;
        end else begin
            s0_acc    <= accept;
            s0_win_ok <= win_ok;
            s0_eol    <= accept && bus.in_eol;
            if (accept) begin
                s0_pix  <= bus.in_data;
                s0_addr <= col_eff;
            end
            s1_acc    <= s0_acc;
            s1_win_ok <= s0_win_ok;
            s1_eol    <= s0_eol;
            s1_pix    <= s0_pix;
            s1_addr   <= s0_addr;
        end
    end

    // Line buffer k holds the line k+1 lines above the incoming one.
    // Buffer 0 is written with the pixel; buffer k>0 is written one cycle
    // later with what buffer k-1 returned at that address.
    genvar gi;
    generate
        for (gi = 0; gi < WIN-1; gi++) begin : g_line_buf
            logic [DATA_W-1:0] mem [LINE_W];
            logic [DATA_W-1:0] ram_q_reg;
            logic              we;
            logic [ADDR_W-1:0] waddr;
            logic [DATA_W-1:0] wdata;

            if (gi == 0) begin : g_head
                assign we            = s0_acc;
                assign waddr         = s0_addr;
                assign wdata         = s0_pix;
                assign rd_data[gi]   = ram_q_reg;
            end else begin : g_chain
                // The chained write for one pixel lands on the same edge as
                // the read for the next; with back-to-back 1-pixel lines both
                // hit the same address, so the written value is forwarded.
                logic              fwd_reg;
                logic [DATA_W-1:0] fwd_data_reg;
                assign we    = s1_acc;
                assign waddr = s1_addr;
                assign wdata = rd_data[gi-1];
                always_ff @(posedge clk) begin
                    if (rst) begin
                        fwd_reg <= 1'b0;
                    end else if (s0_acc) begin
                        fwd_reg <= s1_acc && (s1_addr == s0_addr);
                    end
                    if (s0_acc) begin
                        fwd_data_reg <= rd_data[gi-1];
                    end
                end
                assign rd_data[gi] = fwd_reg ? fwd_data_reg : ram_q_reg;
            end

            always_ff @(posedge clk) begin
                if (s0_acc) begin
                    ram_q_reg <= mem[s0_addr];
                end
                if (we) begin
                    mem[waddr] <= wdata;
                end
            end

            // Oldest line goes to the top row of the incoming column
            assign col_in[WIN-2-gi] = rd_data[gi];
        end
    endgenerate

    assign col_in[WIN-1] = s1_pix;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_eol_reg   <= 1'b0;
        end else begin
            out_valid_reg <= s1_win_ok;
            out_eol_reg   <= s1_win_ok && s1_eol;
            if (s1_acc) begin
                for (int r = 0; r < WIN; r++) begin
                    win_reg[r] <= {col_in[r], win_reg[r][WIN*DATA_W-1:DATA_W]};
                end
            end
        end
    end

    assign bus.out_window  = win_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_eol     = out_eol_reg;
    assign bus.err_overrun = err_reg;

`ifdef WINDOW_COORD_EN
    localparam int HALF = (WIN - 1) / 2;
    logic [15:0]       y_reg, y_next, y_eff;
    logic [ADDR_W-1:0] s0_x, s1_x, x_out_reg;
    logic [15:0]       s0_y, s1_y, y_out_reg;

    // Full lines since in_sof, not saturating
    always_comb begin
        y_eff  = (bus.in_valid && bus.in_sof) ? 16'd0 : y_reg;
        y_next = y_reg;
        if (accept) begin
            y_next = line_end ? y_eff + 16'd1 : y_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg     <= '0;
            s0_x      <= '0;
            s0_y      <= '0;
            s1_x      <= '0;
            s1_y      <= '0;
            x_out_reg <= '0;
            y_out_reg <= '0;
        end else begin
            y_reg <= y_next;
            if (accept) begin
                s0_x <= col_eff - ADDR_W'(HALF);
                s0_y <= y_eff - 16'(HALF);
            end
            s1_x <= s0_x;
            s1_y <= s0_y;
            if (s1_acc) begin
                x_out_reg <= s1_x;
                y_out_reg <= s1_y;
            end
        end
    end

    assign bus.out_x = x_out_reg;
    assign bus.out_y = y_out_reg;
`endif
endmodule

// File: tb/tb_sliding_window_gen.sv
// ---------------------------------------------------------------------------
// tb_sliding_window_gen
// Directed + randomized bench for sliding_window_gen (WIN=3, LINE_W=8).
// A frame-level reference model stores every accepted pixel by its
// (line, column) position and builds expected windows directly from that
// picture; expectations are compared 2 clk after each accepting edge.
// ---------------------------------------------------------------------------
module tb_sliding_window_gen;
    localparam int DW = 8;
    localparam int W  = 3;
    localparam int LW = 8;
    localparam int AW = 3;
    localparam int WB = DW * W * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sliding_window_gen_if #(
        .DATA_W(DW), .WIN(W)
`ifdef WINDOW_COORD_EN
        , .ADDR_W(AW)
`endif
    ) bus ();

    sliding_window_gen #(
        .DATA_W(DW), .WIN(W), .LINE_W(LW), .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit            valid;
        bit            eol;
        logic [WB-1:0] win;
    } exp_t;

    exp_t          pipe[$];
    int            errors = 0;
    int            checks = 0;
    bit            m_active;
    int            m_col, m_line;
    bit            m_err;
    logic [DW-1:0] m_pix [64][LW];
    int            n_valid;
    bit            got_first;
    logic [WB-1:0] first_win;
    logic [WB-1:0] ref_first;

    task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: picture of the current frame indexed by line and column
    function automatic exp_t model(input bit v, input bit sof, input bit eol, input logic [DW-1:0] d);
        exp_t e;
        e.valid = 1'b0;
        e.eol   = 1'b0;
        e.win   = '0;
        if (v && (m_active || sof)) begin
            if (sof) begin
                m_active = 1'b1;
                m_col    = 0;
                m_line   = 0;
            end
            m_pix[m_line % 64][m_col] = d;
            if (m_line >= W-1 && m_col >= W-1) begin
                e.valid = 1'b1;
                e.eol   = eol;
                for (int r = 0; r < W; r++)
                    for (int c = 0; c < W; c++)
                        e.win[(r*W+c)*DW +: DW] = m_pix[(m_line-(W-1)+r) % 64][m_col-(W-1)+c];
            end
            if (eol || m_col == LW-1) begin
                if (!eol) m_err = 1'b1;
                m_col = 0;
                m_line++;
            end else begin
                m_col++;
            end
        end
        return e;
    endfunction

    task automatic cycle(input bit v, input bit sof, input bit eol, input logic [DW-1:0] d);
        exp_t e, o;
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.in_eol   = eol;
        bus.in_data  = d;
        e = model(v, sof, eol, d);
        pipe.push_back(e);
        @(posedge clk);
        #1;
        o = pipe.pop_front();
        check("out_valid", WB'(bus.out_valid), WB'(o.valid));
        check("out_eol", WB'(bus.out_eol), WB'(o.eol));
        if (o.valid) check("out_window", bus.out_window, o.win);
        check("err_overrun", WB'(bus.err_overrun), WB'(m_err));
        if (bus.out_valid === 1'b1) begin
            n_valid++;
            if (!got_first) begin
                got_first = 1'b1;
                first_win = bus.out_window;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'($urandom), 1'($urandom), DW'($urandom));
    endtask

    task automatic do_reset(input int n);
        exp_t z;
        z.valid = 1'b0;
        z.eol   = 1'b0;
        z.win   = '0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eol   = 1'b0;
        bus.in_data  = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_out_valid", WB'(bus.out_valid), WB'(1'b0));
            check("rst_out_eol", WB'(bus.out_eol), WB'(1'b0));
            check("rst_out_window", bus.out_window, WB'(0));
            check("rst_err_overrun", WB'(bus.err_overrun), WB'(1'b0));
        end
        rst = 1'b0;
        m_active = 1'b0;
        m_col    = 0;
        m_line   = 0;
        m_err    = 1'b0;
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
    endtask

    // gap_mode: 0 continuous, 1 alternate idle cycle, 2 random idles
    task automatic frame(input int lines, input int width, input int gap_mode, input bit rnd);
        for (int l = 0; l < lines; l++) begin
            for (int c = 0; c < width; c++) begin
                logic [DW-1:0] d;
                d = rnd ? DW'($urandom) : DW'(l*16 + c);
                cycle(1'b1, (l == 0 && c == 0), (c == width-1), d);
                if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) idle(1);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eol   = 1'b0;
        bus.in_data  = '0;
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                ref_first[(r*W+c)*DW +: DW] = DW'(r*16 + c);

        // Continuous 4x8 frame
        do_reset(2);
        n_valid = 0; got_first = 1'b0;
        frame(4, 8, 0, 1'b0);
        idle(2);
        check("s1_window_count", WB'(n_valid), WB'(12));
        check("s1_first_window", first_win, ref_first);

        // Same frame with in_valid toggling
        n_valid = 0; got_first = 1'b0;
        frame(4, 8, 1, 1'b0);
        idle(2);
        check("s2_window_count", WB'(n_valid), WB'(12));
        check("s2_first_window", first_win, ref_first);

        // Pixels before any in_sof are dropped
        do_reset(2);
        n_valid = 0; got_first = 1'b0;
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, (i % 4) == 3, DW'(8'hA0 + i));
        check("s3_no_valid_before_sof", WB'(n_valid), WB'(0));
        frame(4, 8, 0, 1'b0);
        idle(2);
        check("s3_window_count", WB'(n_valid), WB'(12));
        check("s3_first_window", first_win, ref_first);

        // Overrun: 10 pixels with no in_eol
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, i == 0, 1'b0, DW'(i));
            if (i == 7) check("s4_err_after_8th", WB'(bus.err_overrun), WB'(1'b1));
        end
        for (int c = 2; c < 8; c++) cycle(1'b1, 1'b0, c == 7, DW'(8'h20 + c));
        for (int c = 0; c < 8; c++) cycle(1'b1, 1'b0, c == 7, DW'(8'h40 + c));
        idle(4);
        check("s4_err_sticky", WB'(bus.err_overrun), WB'(1'b1));
        do_reset(2);

        // Second in_sof mid-frame at row 3 col 4
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < ((l == 3) ? 4 : 8); c++)
                cycle(1'b1, l == 0 && c == 0, c == 7, DW'(8'h80 + l*16 + c));
        idle(2);
        n_valid = 0; got_first = 1'b0;
        frame(4, 8, 0, 1'b0);
        idle(2);
        check("s5_window_count", WB'(n_valid), WB'(12));
        check("s5_first_window", first_win, ref_first);

        // Reset during row 2, then input ignored until in_sof
        frame(2, 8, 0, 1'b1);
        for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0, 1'b0, DW'($urandom));
        do_reset(1);
        n_valid = 0;
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, (i % 8) == 7, DW'($urandom));
        check("s6_ignored_until_sof", WB'(n_valid), WB'(0));
        frame(3, 8, 2, 1'b1);
        idle(2);

        // Randomized frames: random width, height, data and gaps
        for (int f = 0; f < 8; f++) begin
            frame($urandom_range(3, 6), $urandom_range(3, 8), 2, 1'b1);
            idle($urandom_range(0, 3));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
